// File: rtl/jump_pkg.sv
// Shared encodings for the Execute-stage jump/branch unit.
//   JOP_*  transfer operation selector on E_jop (6 and 7 act as NONE)
//   EXT_*  immediate extension mode on E_ext_op (3 acts as ZERO)
package jump_pkg;

  localparam logic [2:0] JOP_NONE = 3'd0;
  localparam logic [2:0] JOP_BR   = 3'd1;
  localparam logic [2:0] JOP_J    = 3'd2;
  localparam logic [2:0] JOP_JAL  = 3'd3;
  localparam logic [2:0] JOP_JR   = 3'd4;
  localparam logic [2:0] JOP_JALR = 3'd5;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  function automatic logic jop_taken(input logic [2:0] jop, input logic cond);
    case (jop)
      JOP_BR:                            jop_taken = cond;
      JOP_J, JOP_JAL, JOP_JR, JOP_JALR:  jop_taken = 1'b1;
      default:                           jop_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack.
//   clk, reset  clock and synchronous active-high reset
//   push        write din at sp, advance sp (overwrites oldest when full)
//   pop         retreat sp when non-empty; with push in the same cycle the
//               pop is applied first, so the top entry gets replaced
//   din         address to push
//   top         most recent entry, 0 when empty
//   valid       stack is non-empty
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         valid
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_sp;
  logic [PW:0]   r_cnt;

  logic          w_pop_eff;
  logic [PW-1:0] w_sp_pop;
  logic [PW-1:0] w_sp_top;
  logic [PW:0]   w_cnt_pop;
  logic [PW:0]   w_cnt_push;

  always_comb begin
    w_pop_eff  = pop && (r_cnt != '0);
    w_sp_pop   = w_pop_eff ? r_sp - 1'b1 : r_sp;
    w_cnt_pop  = w_pop_eff ? r_cnt - 1'b1 : r_cnt;
    // count saturates at DEPTH; a push when full just recycles the oldest slot
    w_cnt_push = (w_cnt_pop == FULL) ? FULL : w_cnt_pop + 1'b1;
    w_sp_top   = r_sp - 1'b1;
    valid      = (r_cnt != '0);
    top        = valid ? r_mem[w_sp_top] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (push) begin
      r_mem[w_sp_pop] <= din;
      r_sp            <= w_sp_pop + 1'b1;
      r_cnt           <= w_cnt_push;
    end else begin
      r_sp  <= w_sp_pop;
      r_cnt <= w_cnt_pop;
    end
  end

endmodule

// File: rtl/e_jump_unit.sv
// Execute-stage jump/branch unit: immediate extension, transfer targets,
// registered one-cycle fetch redirect, return-address stack and a
// saturating taken-transfer counter.
//   clk, reset     clock, synchronous active-high reset
//   stall, flush   E-stage stall (freeze) and kill
//   E_*            instruction fields / operands from the E pipeline register
//   E_imm16_EXT    extended imm16 (combinational)
//   E_imm26_EXT    jump target {pc4[31:28], imm26, 00} (combinational)
//   E_link         E_pc + 8 (combinational)
//   redir_valid/pc registered redirect to fetch
//   ras_valid/top  RAS state for fetch-side jr $ra prediction
//   taken_cnt      saturating count of taken transfers
module e_jump_unit
  import jump_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              E_valid,
  input  logic [ADDR_W-1:0] E_pc,
  input  logic [15:0]       E_imm16,
  input  logic [25:0]       E_imm26,
  input  logic [1:0]        E_ext_op,
  input  logic [2:0]        E_jop,
  input  logic              E_cond,
  input  logic [ADDR_W-1:0] E_rs_val,
  input  logic              E_rs_is_ra,
  output logic [ADDR_W-1:0] E_imm16_EXT,
  output logic [ADDR_W-1:0] E_imm26_EXT,
  output logic [ADDR_W-1:0] E_link,
  output logic              redir_valid,
  output logic [ADDR_W-1:0] redir_pc,
  output logic              ras_valid,
  output logic [ADDR_W-1:0] ras_top,
  output logic [CNT_W-1:0]  taken_cnt
);

  logic [ADDR_W-1:0] w_pc4;
  logic [ADDR_W-1:0] w_br_tgt;
  logic [ADDR_W-1:0] w_target;
  logic              w_accept;
  logic              w_take;
  logic              w_push;
  logic              w_pop;

  logic              r_redir_valid;
  logic [ADDR_W-1:0] r_redir_pc;
  logic [CNT_W-1:0]  r_taken_cnt;

  always_comb begin
    w_pc4       = E_pc + ADDR_W'(4);
    E_link      = E_pc + ADDR_W'(8);
    E_imm26_EXT = {w_pc4[ADDR_W-1:28], E_imm26, 2'b00};

    case (E_ext_op)
      EXT_SIGN: E_imm16_EXT = {{(ADDR_W-16){E_imm16[15]}}, E_imm16};
      EXT_LUI:  E_imm16_EXT = ADDR_W'({E_imm16, 16'h0000});
      default:  E_imm16_EXT = ADDR_W'(E_imm16);
    endcase

    w_br_tgt = w_pc4 + {{(ADDR_W-18){E_imm16[15]}}, E_imm16, 2'b00};

    case (E_jop)
      JOP_BR:           w_target = w_br_tgt;
      JOP_J, JOP_JAL:   w_target = E_imm26_EXT;
      JOP_JR, JOP_JALR: w_target = E_rs_val;
      default:          w_target = '0;
    endcase

    w_accept = E_valid && !stall && !flush;
    w_take   = w_accept && jop_taken(E_jop, E_cond);
    w_push   = w_accept && ((E_jop == JOP_JAL) || (E_jop == JOP_JALR));
    w_pop    = w_accept && E_rs_is_ra && ((E_jop == JOP_JR) || (E_jop == JOP_JALR));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_redir_valid <= 1'b0;
      r_redir_pc    <= '0;
      r_taken_cnt   <= '0;
    end else begin
      // flush kills the redirect even while stalled
      if (flush)       r_redir_valid <= 1'b0;
      else if (!stall) r_redir_valid <= w_take;
      if (w_take) begin
        r_redir_pc <= w_target;
        if (r_taken_cnt != '1) r_taken_cnt <= r_taken_cnt + 1'b1;
      end
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (E_link),
    .top   (ras_top),
    .valid (ras_valid)
  );

  assign redir_valid = r_redir_valid;
  assign redir_pc    = r_redir_pc;
  assign taken_cnt   = r_taken_cnt;

endmodule
